burst_port_ctrl_vh: RTL and testbench

//  Downstream consumer of the one-hot core grant: locks the granted core as owner of the

---
 rtl/burst_port_ctrl_vh.sv | 131 +++++++++++++
 tb/tb_burst_port_ctrl_vh.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_port_ctrl_vh.sv
// Shared write-port owner: locks the granted core, streams a fixed-length burst into
// shared memory, then releases the port with a done (or abort) strobe back to that core.
`ifndef NUM_CORE_V
`define NUM_CORE_V 10
`endif

module burst_port_ctrl_vh #(
  parameter int NUM_CORE  = `NUM_CORE_V,
  parameter int IDX_W     = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int BURST_LEN = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_CORE-1:0]        core_req_i,
  input  logic [NUM_CORE-1:0]        arb_grant_i,
  input  logic [NUM_CORE*DATA_W-1:0] core_wdata_i,
  input  logic [NUM_CORE*ADDR_W-1:0] core_waddr_i,
  output logic [NUM_CORE-1:0]        core_ack_o,
  output logic [NUM_CORE-1:0]        core_done_o,
  output logic [NUM_CORE-1:0]        core_abort_o,
  output logic                       mem_we_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [DATA_W-1:0]          mem_wdata_o,
  output logic                       busy_o,
  output logic [IDX_W-1:0]           owner_idx_o,
  output logic                       grant_err_o
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_e;

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_e                state_q;
  logic [NUM_CORE-1:0]   owner_q;
  logic [IDX_W-1:0]      owner_idx_q;
  logic [ADDR_W-1:0]     base_q;
  logic [7:0]            beat_q;
  logic                  grant_err_q;

  logic                  grant_any;
  logic                  grant_multi;
  logic [IDX_W-1:0]      grant_idx;
  logic [ADDR_W-1:0]     grant_base;
  logic                  owner_req;
  logic [DATA_W-1:0]     owner_wdata;
  logic                  in_burst;
  logic                  write_beat;

  // x & (x-1) is nonzero exactly when more than one grant bit is set
  assign grant_any   = |arb_grant_i;
  assign grant_multi = |(arb_grant_i & (arb_grant_i - NUM_CORE'(1)));

  always_comb begin
    grant_idx  = '0;
    grant_base = '0;
    for (int i = 0; i < NUM_CORE; i++) begin
      if (arb_grant_i[i]) begin
        grant_idx  = IDX_W'(i);
        grant_base = core_waddr_i[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    owner_wdata = '0;
    for (int i = 0; i < NUM_CORE; i++) begin
      if (owner_q[i]) owner_wdata = core_wdata_i[i*DATA_W +: DATA_W];
    end
  end

  assign owner_req = |(core_req_i & owner_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      owner_idx_q <= '0;
      base_q      <= '0;
      beat_q      <= '0;
      grant_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_multi) begin
            grant_err_q <= 1'b1;
          end else if (grant_any) begin
            owner_q     <= arb_grant_i;
            owner_idx_q <= grant_idx;
            base_q      <= grant_base;
            beat_q      <= '0;
            state_q     <= BURST;
          end
        end
        BURST: begin
          // a dropped request ends the burst early with no done strobe
          if (!owner_req) begin
            owner_q     <= '0;
            owner_idx_q <= '0;
            state_q     <= IDLE;
          end else if (beat_q == LAST_BEAT) begin
            state_q <= DONE;
          end else begin
            beat_q <= beat_q + 8'd1;
          end
        end
        DONE: begin
          owner_q     <= '0;
          owner_idx_q <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_burst   = (state_q == BURST);
  assign write_beat = in_burst && owner_req;

  assign mem_we_o     = write_beat;
  assign mem_addr_o   = write_beat ? base_q + ADDR_W'(beat_q) : '0;
  assign mem_wdata_o  = write_beat ? owner_wdata : '0;
  assign core_ack_o   = write_beat ? owner_q : '0;
  assign core_abort_o = (in_burst && !owner_req) ? owner_q : '0;
  assign core_done_o  = (state_q == DONE) ? owner_q : '0;
  assign busy_o       = (state_q != IDLE);
  assign owner_idx_o  = owner_idx_q;
  assign grant_err_o  = grant_err_q;

endmodule

// File: tb/tb_burst_port_ctrl_vh.sv
// Bench for burst_port_ctrl_vh: directed scenarios, a per-cycle burst model that
// derives every output from the beat index, and literal spot checks.
module tb_burst_port_ctrl_vh;

  localparam int NC  = 10;
  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int LEN = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NC-1:0]    core_req = '0;
  logic [NC-1:0]    arb_grant = '0;
  logic [NC*DW-1:0] core_wdata = '0;
  logic [NC*AW-1:0] core_waddr = '0;
  logic [NC-1:0]    core_ack;
  logic [NC-1:0]    core_done;
  logic [NC-1:0]    core_abort;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             busy;
  logic [3:0]       owner_idx;
  logic             grant_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit mBusy = 1'b0;
  bit mErr = 1'b0;
  int mOwner = 0;
  int mBase = 0;
  int mStart = 0;

  burst_port_ctrl_vh dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .core_req_i   (core_req),
    .arb_grant_i  (arb_grant),
    .core_wdata_i (core_wdata),
    .core_waddr_i (core_waddr),
    .core_ack_o   (core_ack),
    .core_done_o  (core_done),
    .core_abort_o (core_abort),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .busy_o       (busy),
    .owner_idx_o  (owner_idx),
    .grant_err_o  (grant_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NC-1:0] grant, input logic [NC-1:0] req);
    arb_grant = grant;
    core_req  = req;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setBase(input int core, input logic [AW-1:0] base);
    core_waddr[core*AW +: AW] = base;
  endtask

  // each core's data word names the core and the cycle it is presented in
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NC; i++) core_wdata[i*DW +: DW] = {4'(i), 12'(cyc)};
  end

  // burst model: an accepted grant fixes owner, base and the cycle of beat 0
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy = 1'b0;
      mErr  = 1'b0;
    end else if (!mBusy) begin
      if ($onehot(arb_grant)) begin
        for (int i = 0; i < NC; i++) if (arb_grant[i]) mOwner = i;
        mBase  = int'(core_waddr[mOwner*AW +: AW]);
        mStart = cyc + 1;
        mBusy  = 1'b1;
      end else if (arb_grant != '0) begin
        mErr = 1'b1;
      end
    end else begin
      if ((cyc - mStart) >= LEN || !core_req[mOwner]) mBusy = 1'b0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    int k;
    logic          eWe, eBusy;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eData;
    logic [NC-1:0] eAck, eDone, eAbort;
    logic [3:0]    eIdx;
    eWe = 1'b0; eBusy = 1'b0; eAddr = '0; eData = '0;
    eAck = '0; eDone = '0; eAbort = '0; eIdx = '0;
    if (mBusy) begin
      k     = cyc - mStart;
      eBusy = 1'b1;
      eIdx  = 4'(mOwner);
      if (k >= LEN) begin
        eDone = NC'(1) << mOwner;
      end else if (core_req[mOwner]) begin
        eWe   = 1'b1;
        eAddr = AW'((mBase + k) % (1 << AW));
        eData = {4'(mOwner), 12'(cyc)};
        eAck  = NC'(1) << mOwner;
      end else begin
        eAbort = NC'(1) << mOwner;
      end
    end
    checkOutput("mem_we", 32'(mem_we), 32'(eWe));
    checkOutput("mem_addr", 32'(mem_addr), 32'(eAddr));
    checkOutput("mem_wdata", 32'(mem_wdata), 32'(eData));
    checkOutput("core_ack", 32'(core_ack), 32'(eAck));
    checkOutput("core_done", 32'(core_done), 32'(eDone));
    checkOutput("core_abort", 32'(core_abort), 32'(eAbort));
    checkOutput("busy", 32'(busy), 32'(eBusy));
    checkOutput("owner_idx", 32'(owner_idx), 32'(eIdx));
    checkOutput("grant_err", 32'(grant_err), 32'(mErr));
  end

  initial begin
    logic [AW-1:0] addrs1 [LEN];
    logic [AW-1:0] addrs2 [LEN];
    addrs1 = '{12'h0FE, 12'h0FF, 12'h100, 12'h101, 12'h102, 12'h103, 12'h104, 12'h105};
    addrs2 = '{12'hFFD, 12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h002, 12'h003, 12'h004};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    rst_n = 1'b1;
    tick();

    // single full burst from core 3
    setBase(3, 12'h0FE);
    applyStimulus(10'h008, 10'h008);
    tick();
    applyStimulus(10'h000, 10'h008);
    for (int k = 0; k < LEN; k++) begin
      @(negedge clk);
      checkOutput("t1_addr", 32'(mem_addr), 32'(addrs1[k]));
      checkOutput("t1_ack", 32'(core_ack), 32'h008);
      checkOutput("t1_idx", 32'(owner_idx), 32'd3);
      tick();
    end
    @(negedge clk);
    checkOutput("t1_done", 32'(core_done), 32'h008);
    checkOutput("t1_done_we", 32'(mem_we), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t1_idle_busy", 32'(busy), 32'd0);
    checkOutput("t1_idle_idx", 32'(owner_idx), 32'd0);
    applyStimulus(10'h000, 10'h000);
    tick();

    // address wrap
    setBase(3, 12'hFFD);
    applyStimulus(10'h008, 10'h008);
    tick();
    applyStimulus(10'h000, 10'h008);
    for (int k = 0; k < LEN; k++) begin
      @(negedge clk);
      checkOutput("t2_addr", 32'(mem_addr), 32'(addrs2[k]));
      tick();
    end
    @(negedge clk);
    checkOutput("t2_done", 32'(core_done), 32'h008);
    tick();
    applyStimulus(10'h000, 10'h000);
    tick();

    // request dropped at beat 4
    setBase(3, 12'h200);
    applyStimulus(10'h008, 10'h008);
    tick();
    applyStimulus(10'h000, 10'h008);
    repeat (4) tick();
    applyStimulus(10'h000, 10'h000);
    @(negedge clk);
    checkOutput("t3_abort", 32'(core_abort), 32'h008);
    checkOutput("t3_abort_we", 32'(mem_we), 32'd0);
    checkOutput("t3_abort_ack", 32'(core_ack), 32'h000);
    tick();
    @(negedge clk);
    checkOutput("t3_idle_busy", 32'(busy), 32'd0);
    checkOutput("t3_no_done", 32'(core_done), 32'h000);
    tick();

    // multi-hot grant, then a valid burst from core 0
    applyStimulus(10'h005, 10'h005);
    tick();
    applyStimulus(10'h000, 10'h000);
    @(negedge clk);
    checkOutput("t4_err", 32'(grant_err), 32'd1);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    tick();
    setBase(0, 12'h010);
    applyStimulus(10'h001, 10'h001);
    tick();
    applyStimulus(10'h000, 10'h001);
    @(negedge clk);
    checkOutput("t4_addr", 32'(mem_addr), 32'h010);
    checkOutput("t4_ack", 32'(core_ack), 32'h001);
    repeat (9) tick();
    applyStimulus(10'h000, 10'h000);
    tick();

    // grant moves to core 9 mid-burst of core 3
    setBase(3, 12'h300);
    setBase(9, 12'h900);
    applyStimulus(10'h008, 10'h208);
    tick();
    applyStimulus(10'h200, 10'h208);
    repeat (8) tick();
    @(negedge clk);
    checkOutput("t5_done", 32'(core_done), 32'h008);
    checkOutput("t5_done_idx", 32'(owner_idx), 32'd3);
    tick();
    @(negedge clk);
    checkOutput("t5_gap_busy", 32'(busy), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t5_c9_idx", 32'(owner_idx), 32'd9);
    checkOutput("t5_c9_addr", 32'(mem_addr), 32'h900);
    checkOutput("t5_c9_ack", 32'(core_ack), 32'h200);
    applyStimulus(10'h000, 10'h200);
    repeat (9) tick();
    checkOutput("t5_err_sticky", 32'(grant_err), 32'd1);
    applyStimulus(10'h000, 10'h000);
    tick();

    // asynchronous reset at beat 2 of core 5
    setBase(5, 12'h050);
    applyStimulus(10'h020, 10'h020);
    tick();
    applyStimulus(10'h000, 10'h020);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_we", 32'(mem_we), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_ack", 32'(core_ack), 32'h000);
    checkOutput("t6_addr", 32'(mem_addr), 32'h000);
    checkOutput("t6_idx", 32'(owner_idx), 32'd0);
    checkOutput("t6_err", 32'(grant_err), 32'd0);
    checkOutput("t6_pulses", 32'({core_done, core_abort}), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(10'h000, 10'h000);
    tick();

    // grant to a core that is not requesting aborts on its first beat
    setBase(2, 12'h7F0);
    applyStimulus(10'h004, 10'h000);
    tick();
    applyStimulus(10'h000, 10'h000);
    @(negedge clk);
    checkOutput("t7_abort", 32'(core_abort), 32'h004);
    checkOutput("t7_we", 32'(mem_we), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t7_idle", 32'(busy), 32'd0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
